tetris_cmd_ctrl: RTL and testbench
==================================

Name: tetris_cmd_ctrl

Overview:
Second-generation game input controller. It merges debounced push-buttons, UART keystrokes and an internal gravity timer into one command stream, buffered by a parametrised FIFO with a valid/ready handshake to the game FSM. It adds held-key auto-repeat, level-scaled gravity and a saturating countdown timer. It sits between the I/O front end (debouncers, uart) and the board/game state machine.

Parameters:
DEPTH, 8, FIFO entries; power of 2, ≥2
SEC_TICK, 100_000_000, clk cycles per second
DAS_TICK, 20_000_000, held-key delay before first repeat
ARR_TICK, 5_000_000, held-key repeat period
GRAV_BASE, 100_000_000, gravity period at level 0
GRAV_MIN, 6_250_000, gravity period floor
LINES_PER_LEVEL, 4, score_inc pulses per level step
MAX_LEVEL, 15, level saturation
COUNT_INIT, 60, countdown start (s)
BONUS_SEC, 1, seconds added per score_inc
COUNT_MAX, 999, countdown saturation

Ports:
clk  in  1  clock
reset_n  in  1  reset
btn  in  4  debounced levels: [0]RIGHT [1]DOWN [2]ROTATE [3]LEFT
rx_valid  in  1  one-cycle strobe, rx_byte valid
rx_byte  in  8  UART byte
game_run  in  1  high while a game is active
score_inc  in  1  one-cycle line-clear pulse
cmd_ready  in  1  game FSM accepts a command
cmd_valid  out  1  FIFO non-empty
cmd  out  4  head command: 0 NONE, 1 LEFT, 2 RIGHT, 3 DOWN, 4 ROTATE, 5 ROTATE_REV, 6 DROP, 7 HOLD, 8 BAR
fifo_count  out  $clog2(DEPTH)+1  occupancy
overflow  out  1  sticky; a command was dropped on full
level  out  4  current level
count_down  out  10  seconds remaining
time_up  out  1  count_down==0 while game_run

Behaviour:
- Reset: synchronous, active-low, reset_n; clock clk. All outputs 0 except count_down=COUNT_INIT; FIFO empty; escape FSM IDLE.
- FIFO: show-ahead. Pop when cmd_valid&&cmd_ready. A push at cycle t is visible at t+1. Push+pop in the same cycle is allowed when full (count unchanged). Push when full and not popping: drop and set overflow. overflow clears only on reset or a game_run rising edge.
- Source priority: at most one push per cycle, UART > button > gravity. A losing button event is lost. A losing gravity event stays pending: its counter holds at threshold until pushed.
- UART decode: A/a LEFT, D/d RIGHT, S/s DOWN, W/w/space DROP, C/c HOLD, X/x ROTATE, Z/z ROTATE_REV, B/b BAR; other bytes ignored.
- Escape FSM for arrow keys: IDLE -(0x1B)-> ESC -(0x5B)-> CSI. In CSI, 0x41 ROTATE, 0x42 DOWN, 0x43 RIGHT, 0x44 LEFT, then IDLE. Any other byte returns to IDLE with no push. A byte consumed by ESC/CSI does not go through single-key decode.
- Buttons: a rising edge pushes immediately. While held, after DAS_TICK cycles it repeats every ARR_TICK, for LEFT/RIGHT/DOWN only; ROTATE never repeats. Multiple simultaneous edges are pushed lowest index first, one per cycle.
- Gravity: period = max(GRAV_BASE>>level, GRAV_MIN). The counter restarts on push and on any accepted DOWN from another source.
- Level: increments every LINES_PER_LEVEL score_inc pulses and saturates at MAX_LEVEL.
- Countdown: decrements once per SEC_TICK while game_run. score_inc adds BONUS_SEC, saturating at COUNT_MAX. A second tick and a bonus in the same cycle net to the sum. Holds at 0, asserting time_up.
- game_run low: no source pushes; timers, level and count_down reload; the FIFO still drains. game_run dropping mid-operation flushes the FIFO on the next cycle.

Optional Feature:
CMD_PAUSE_EN: when defined, UART 'P'/'p' toggles an internal pause bit. While paused:
- gravity, countdown and DAS/ARR counters freeze;
- only 'P' is decoded;
- buttons are ignored.
Pause clears on reset or game_run low. When undefined, 'P' is an ignored byte and no pause logic exists.

Test Plan:
- Reset, then rx 'a','D',' ' with cmd_ready=0 -> fifo_count=3; popping yields 1,2,6 in order, then cmd_valid=0.
- rx 0x1B,0x5B,0x43 -> a single cmd 2 (RIGHT); rx 0x1B,'q' -> no push, FSM back to IDLE.
- Hold btn[3] for DAS_TICK+2*ARR_TICK with cmd_ready=1 -> exactly 3 LEFT pops; holding btn[2] gives exactly 1 ROTATE.
- With cmd_ready=0, push DEPTH+1 commands -> fifo_count=DEPTH, overflow=1. Push+pop in the same cycle while full -> count stays DEPTH, no new drop.
- 8 score_inc pulses with LINES_PER_LEVEL=4 -> level=2 and gravity period GRAV_BASE/4. A UART DOWN colliding with the gravity expiry -> UART pushes first, gravity restarts.
- count_down=1: a second tick and score_inc in the same cycle -> count_down=1; with no bonus, the next tick gives 0 and time_up=1.

Source files
------------

// File: rtl/tetris_cmd_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tetris_cmd_ctrl_if : valid/ready command channel to the game FSM           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface tetris_cmd_ctrl_if;
  logic       cmd_valid;
  logic [3:0] cmd;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/tetris_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tetris_cmd_ctrl : merges UART keys, buttons (DAS/ARR) and gravity into a   |
// | show-ahead command FIFO; level and countdown. Option macro: CMD_PAUSE_EN   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tetris_cmd_ctrl #(
  parameter int DEPTH           = 8,
  parameter int SEC_TICK        = 100_000_000,
  parameter int DAS_TICK        = 20_000_000,
  parameter int ARR_TICK        = 5_000_000,
  parameter int GRAV_BASE       = 100_000_000,
  parameter int GRAV_MIN        = 6_250_000,
  parameter int LINES_PER_LEVEL = 4,
  parameter int MAX_LEVEL       = 15,
  parameter int COUNT_INIT      = 60,
  parameter int BONUS_SEC       = 1,
  parameter int COUNT_MAX       = 999
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [3:0]               btn_i,
  input  logic                     rx_valid_i,
  input  logic [7:0]               rx_byte_i,
  input  logic                     game_run_i,
  input  logic                     score_inc_i,
  tetris_cmd_ctrl_if.master        cmd_if,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     overflow_o,
  output logic [3:0]               level_o,
  output logic [9:0]               count_down_o,
  output logic                     time_up_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REP_W = $clog2(((DAS_TICK > ARR_TICK) ? DAS_TICK : ARR_TICK) + 1);
  localparam int GW    = $clog2(GRAV_BASE + 1);
  localparam int LW    = $clog2(LINES_PER_LEVEL + 1);
  localparam int SW    = $clog2(SEC_TICK + 1);

  localparam logic [3:0] CMD_NONE   = 4'd0;
  localparam logic [3:0] CMD_LEFT   = 4'd1;
  localparam logic [3:0] CMD_RIGHT  = 4'd2;
  localparam logic [3:0] CMD_DOWN   = 4'd3;
  localparam logic [3:0] CMD_ROT    = 4'd4;
  localparam logic [3:0] CMD_ROTREV = 4'd5;
  localparam logic [3:0] CMD_DROP   = 4'd6;
  localparam logic [3:0] CMD_HOLD   = 4'd7;
  localparam logic [3:0] CMD_BAR    = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ESC  = 2'd1;
  localparam logic [1:0] ST_CSI  = 2'd2;

  logic          run_q;
  logic          w_run_rise, w_run_fall;
  logic          w_paused, w_active;
  logic [1:0]    esc_q, esc_d;
  logic [3:0]    w_uart_cmd;
  logic          w_uart_push;
  logic [3:0]    btn_q, pend_q, pend_d;
  logic [3:0]    w_rise, w_rep, w_btn_evt, w_btn_sel, w_btn_cmd;
  logic          w_btn_push;
  logic [GW-1:0] grav_q, w_grav_shr, w_grav_per;
  logic          w_grav_evt, w_grav_push;
  logic          w_push, w_pop, w_full, w_valid, w_wr_en, w_drop;
  logic [3:0]    w_push_cmd;
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic [LW-1:0] lines_q;
  logic [3:0]    level_q;
  logic [SW-1:0] sec_q;
  logic          w_sec_tick;
  logic [10:0]   w_cnt_sum;
  logic [9:0]    count_q;

  assign w_run_rise = game_run_i & ~run_q;
  assign w_run_fall = ~game_run_i & run_q;
  assign w_active   = game_run_i & ~w_paused;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_q <= 1'b0;
      btn_q <= 4'd0;
    end else begin
      run_q <= game_run_i;
      btn_q <= btn_i;
    end
  end

`ifdef CMD_PAUSE_EN
  logic pause_q;
  logic w_pause_tgl;

  always_ff @(posedge clk) begin
    if (!reset_n || !game_run_i) pause_q <= 1'b0;
    else if (w_pause_tgl)        pause_q <= ~pause_q;
  end
  assign w_paused = pause_q;
`else
  assign w_paused = 1'b0;
`endif

  // Escape-sequence FSM: state register / next state / decode outputs
  always_ff @(posedge clk) begin
    if (!reset_n) esc_q <= ST_IDLE;
    else          esc_q <= esc_d;
  end

  always_comb begin
    esc_d = esc_q;
    if (!game_run_i) begin
      esc_d = ST_IDLE;
    end else if (rx_valid_i && !w_paused) begin
      case (esc_q)
        ST_IDLE: if (rx_byte_i == 8'h1B) esc_d = ST_ESC;
        ST_ESC:  esc_d = (rx_byte_i == 8'h5B) ? ST_CSI : ST_IDLE;
        default: esc_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_uart_cmd = CMD_NONE;
`ifdef CMD_PAUSE_EN
    w_pause_tgl = 1'b0;
`endif
    if (game_run_i && rx_valid_i) begin
      case (esc_q)
        ST_IDLE: begin
          if (!w_paused) begin
            case (rx_byte_i)
              8'h41, 8'h61:        w_uart_cmd = CMD_LEFT;
              8'h44, 8'h64:        w_uart_cmd = CMD_RIGHT;
              8'h53, 8'h73:        w_uart_cmd = CMD_DOWN;
              8'h57, 8'h77, 8'h20: w_uart_cmd = CMD_DROP;
              8'h43, 8'h63:        w_uart_cmd = CMD_HOLD;
              8'h58, 8'h78:        w_uart_cmd = CMD_ROT;
              8'h5A, 8'h7A:        w_uart_cmd = CMD_ROTREV;
              8'h42, 8'h62:        w_uart_cmd = CMD_BAR;
              default:             w_uart_cmd = CMD_NONE;
            endcase
          end
`ifdef CMD_PAUSE_EN
          w_pause_tgl = (rx_byte_i == 8'h50) || (rx_byte_i == 8'h70);
`endif
        end
        ST_CSI: begin
          case (rx_byte_i)
            8'h41:   w_uart_cmd = CMD_ROT;
            8'h42:   w_uart_cmd = CMD_DOWN;
            8'h43:   w_uart_cmd = CMD_RIGHT;
            8'h44:   w_uart_cmd = CMD_LEFT;
            default: w_uart_cmd = CMD_NONE;
          endcase
        end
        default: w_uart_cmd = CMD_NONE;
      endcase
    end
  end

  assign w_uart_push = (w_uart_cmd != CMD_NONE);

  // Per-button auto-repeat; ROTATE (index 2) has none
  for (genvar gi = 0; gi < 4; gi++) begin : g_rep
    if (gi == 2) begin : g_norep
      assign w_rep[gi] = 1'b0;
    end else begin : g_das
      logic [REP_W-1:0] rcnt_q;
      logic             das_q;

      always_ff @(posedge clk) begin
        if (!reset_n || !game_run_i || !btn_i[gi]) begin
          rcnt_q <= '0;
          das_q  <= 1'b0;
        end else if (!w_paused) begin
          if (w_rep[gi]) begin
            rcnt_q <= REP_W'(1);
            das_q  <= 1'b1;
          end else begin
            rcnt_q <= rcnt_q + REP_W'(1);
          end
        end
      end

      assign w_rep[gi] = btn_i[gi] && game_run_i &&
                         (das_q ? (rcnt_q == REP_W'(ARR_TICK)) : (rcnt_q == REP_W'(DAS_TICK)));
    end
  end

  // The lowest pending event is served each cycle; if UART wins it is lost
  assign w_rise     = btn_i & ~btn_q;
  assign w_btn_evt  = w_active ? (pend_q | w_rise | w_rep) : 4'd0;
  assign w_btn_sel  = w_btn_evt & (~w_btn_evt + 4'd1);
  assign pend_d     = w_btn_evt & ~w_btn_sel;
  assign w_btn_push = |w_btn_evt;

  always_comb begin
    case (w_btn_sel)
      4'b0001: w_btn_cmd = CMD_RIGHT;
      4'b0010: w_btn_cmd = CMD_DOWN;
      4'b0100: w_btn_cmd = CMD_ROT;
      4'b1000: w_btn_cmd = CMD_LEFT;
      default: w_btn_cmd = CMD_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) pend_q <= 4'd0;
    else          pend_q <= pend_d;
  end

  assign w_grav_shr  = GW'(GRAV_BASE) >> level_q;
  assign w_grav_per  = (w_grav_shr < GW'(GRAV_MIN)) ? GW'(GRAV_MIN) : w_grav_shr;
  assign w_grav_evt  = w_active && (grav_q >= (w_grav_per - GW'(1)));
  assign w_grav_push = w_grav_evt && !w_uart_push && !w_btn_push;

  assign w_push     = w_uart_push | w_btn_push | w_grav_evt;
  assign w_push_cmd = w_uart_push ? w_uart_cmd :
                      w_btn_push  ? w_btn_cmd  :
                      w_grav_evt  ? CMD_DOWN   : CMD_NONE;

  // Gravity holds at threshold while it loses arbitration
  always_ff @(posedge clk) begin
    if (!reset_n || !game_run_i) begin
      grav_q <= '0;
    end else if (!w_paused) begin
      if (w_grav_push || (w_wr_en && (w_push_cmd == CMD_DOWN))) grav_q <= '0;
      else if (!w_grav_evt)                                     grav_q <= grav_q + GW'(1);
    end
  end

  assign w_valid = (cnt_q != '0);
  assign w_full  = (cnt_q == (AW+1)'(DEPTH));
  assign w_pop   = w_valid && cmd_if.cmd_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr_en) mem_q[wr_q] <= w_push_cmd;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || w_run_fall) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_wr_en) wr_q <= wr_q + AW'(1);
      if (w_pop)   rd_q <= rd_q + AW'(1);
      case ({w_wr_en, w_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)        ovf_q <= 1'b0;
    else if (w_drop)     ovf_q <= 1'b1;
    else if (w_run_rise) ovf_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !game_run_i) begin
      lines_q <= '0;
      level_q <= 4'd0;
    end else if (score_inc_i) begin
      if (lines_q == LW'(LINES_PER_LEVEL - 1)) begin
        lines_q <= '0;
        if (level_q != 4'(MAX_LEVEL)) level_q <= level_q + 4'd1;
      end else begin
        lines_q <= lines_q + LW'(1);
      end
    end
  end

  assign w_sec_tick = w_active && (sec_q == SW'(SEC_TICK - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || !game_run_i) sec_q <= '0;
    else if (!w_paused)          sec_q <= w_sec_tick ? '0 : sec_q + SW'(1);
  end

  // Tick and bonus combine into one signed step; decrement suppressed at zero
  assign w_cnt_sum = {1'b0, count_q}
                   + (score_inc_i ? 11'(BONUS_SEC) : 11'd0)
                   - ((w_sec_tick && (count_q != 10'd0)) ? 11'd1 : 11'd0);

  always_ff @(posedge clk) begin
    if (!reset_n || !game_run_i) count_q <= 10'(COUNT_INIT);
    else count_q <= (w_cnt_sum > 11'(COUNT_MAX)) ? 10'(COUNT_MAX) : w_cnt_sum[9:0];
  end

  assign cmd_if.cmd_valid = w_valid;
  assign cmd_if.cmd       = w_valid ? mem_q[rd_q] : CMD_NONE;
  assign fifo_count_o     = cnt_q;
  assign overflow_o       = ovf_q;
  assign level_o          = level_q;
  assign count_down_o     = count_q;
  assign time_up_o        = game_run_i && (count_q == 10'd0);

endmodule
`default_nettype wire

// File: tb/tb_tetris_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tetris_cmd_ctrl : scoreboard bench for tetris_cmd_ctrl (small timings)  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_tetris_cmd_ctrl;

  localparam int DEPTH      = 4;
  localparam int SEC_TICK   = 20;
  localparam int DAS_TICK   = 12;
  localparam int ARR_TICK   = 5;
  localparam int GRAV_BASE  = 256;
  localparam int GRAV_MIN   = 16;
  localparam int LPL        = 4;
  localparam int COUNT_INIT = 3;

  logic       clk;
  logic       reset_n;
  logic [3:0] btn;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       game_run;
  logic       score_inc;
  logic [$clog2(DEPTH):0] fifo_count;
  logic       overflow;
  logic [3:0] level;
  logic [9:0] count_down;
  logic       time_up;

  tetris_cmd_ctrl_if ifc ();

  tetris_cmd_ctrl #(
    .DEPTH(DEPTH), .SEC_TICK(SEC_TICK), .DAS_TICK(DAS_TICK), .ARR_TICK(ARR_TICK),
    .GRAV_BASE(GRAV_BASE), .GRAV_MIN(GRAV_MIN), .LINES_PER_LEVEL(LPL),
    .MAX_LEVEL(15), .COUNT_INIT(COUNT_INIT), .BONUS_SEC(1), .COUNT_MAX(999)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_i(btn), .rx_valid_i(rx_valid),
    .rx_byte_i(rx_byte), .game_run_i(game_run), .score_inc_i(score_inc),
    .cmd_if(ifc), .fifo_count_o(fifo_count), .overflow_o(overflow),
    .level_o(level), .count_down_o(count_down), .time_up_o(time_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_chk   = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         pop_cnt = 0;
  bit         mon_en  = 1'b0;
  logic [3:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic restart();
    mon_en   = 1'b0;
    game_run = 1'b0;
    step();
    step();
    exp_q.delete();
    game_run = 1'b1;
    step();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !ifc.cmd_valid) break;
      step();
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string tag, output int t);
    for (int i = 0; i < 400; i++) begin
      if (ifc.cmd_valid) break;
      step();
    end
    check_eq(tag, ifc.cmd_valid, 1);
    t = cyc;
  endtask

  // Pops are scored at the falling edge, ahead of the edge that performs them
  always @(negedge clk) begin
    if (mon_en && reset_n && ifc.cmd_valid && ifc.cmd_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) check_eq("pop_unexpected", ifc.cmd, 0);
      else                   check_eq("pop_cmd", ifc.cmd, exp_q.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1, e2, e3, e;
    reset_n = 1'b0; btn = 4'd0; rx_valid = 1'b0; rx_byte = 8'd0;
    game_run = 1'b0; score_inc = 1'b0; ifc.cmd_ready = 1'b0;
    repeat (3) step();
    check_eq("rst_valid", ifc.cmd_valid, 0);
    check_eq("rst_count", fifo_count, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_countdown", count_down, COUNT_INIT);
    check_eq("rst_timeup", time_up, 0);
    reset_n = 1'b1;
    step();

    // Single-key decode and FIFO order
    game_run = 1'b1;
    step();
    mon_en = 1'b1;
    send_rx("a"); exp_q.push_back(4'd1);
    send_rx("D"); exp_q.push_back(4'd2);
    send_rx(" "); exp_q.push_back(4'd6);
    check_eq("fifo3_count", fifo_count, 3);
    check_eq("fifo3_head", ifc.cmd, 1);
    ifc.cmd_ready = 1'b1;
    drain("fifo3_drain");
    check_eq("fifo3_empty_valid", ifc.cmd_valid, 0);
    check_eq("fifo3_empty_count", fifo_count, 0);

    // Escape sequences
    restart();
    mon_en = 1'b1;
    send_rx(8'h1B); send_rx(8'h5B); send_rx(8'h43); exp_q.push_back(4'd2);
    drain("esc_right");
    send_rx(8'h1B); send_rx("q");
    repeat (3) step();
    check_eq("esc_abort_count", fifo_count, 0);
    send_rx(8'h43); exp_q.push_back(4'd7);
    drain("esc_idle_hold");

    // Auto-repeat: LEFT repeats, ROTATE does not
    restart();
    mon_en = 1'b1;
    pop_cnt = 0;
    repeat (3) exp_q.push_back(4'd1);
    btn = 4'b1000;
    repeat (DAS_TICK + 2*ARR_TICK) step();
    btn = 4'b0000;
    repeat (10) step();
    check_eq("das_left_pops", pop_cnt, 3);
    check_eq("das_left_queue", exp_q.size(), 0);
    pop_cnt = 0;
    exp_q.push_back(4'd4);
    btn = 4'b0100;
    repeat (DAS_TICK + 3*ARR_TICK) step();
    btn = 4'b0000;
    repeat (10) step();
    check_eq("rot_pops", pop_cnt, 1);

    // Overflow and push+pop while full
    restart();
    mon_en = 1'b1;
    ifc.cmd_ready = 1'b0;
    send_rx("a"); exp_q.push_back(4'd1);
    send_rx("d"); exp_q.push_back(4'd2);
    send_rx("s"); exp_q.push_back(4'd3);
    send_rx("x"); exp_q.push_back(4'd4);
    send_rx("w");
    check_eq("ovf_count", fifo_count, DEPTH);
    check_eq("ovf_flag", overflow, 1);
    ifc.cmd_ready = 1'b1;
    rx_byte = "c"; rx_valid = 1'b1; exp_q.push_back(4'd7);
    step();
    rx_valid = 1'b0;
    ifc.cmd_ready = 1'b0;
    check_eq("full_pushpop_count", fifo_count, DEPTH);
    check_eq("full_pushpop_ovf", overflow, 1);
    ifc.cmd_ready = 1'b1;
    drain("ovf_drain");
    restart();
    check_eq("ovf_clear_on_rise", overflow, 0);

    // Level scaling and gravity period; UART DOWN on gravity expiry
    for (int i = 0; i < 8; i++) begin
      score_inc = 1'b1; step();
      score_inc = 1'b0; step();
    end
    check_eq("level_after_8", level, 2);
    wait_valid("grav_first", e1);
    check_eq("grav_first_cmd", ifc.cmd, 3);
    step();
    wait_valid("grav_second", e2);
    check_eq("grav_period_lvl2", e2 - e1, GRAV_BASE / 4);
    step();
    while (cyc < e2 + GRAV_BASE/4 - 1) step();
    rx_byte = "s"; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check_eq("collide_valid", ifc.cmd_valid, 1);
    check_eq("collide_cmd", ifc.cmd, 3);
    check_eq("collide_count", fifo_count, 1);
    e = cyc;
    step();
    wait_valid("grav_after_collide", e3);
    check_eq("grav_restart_gap", e3 - e, GRAV_BASE / 4);

    // Countdown: tick+bonus nets to zero change, then expiry
    restart();
    for (int i = 0; i < 200; i++) begin
      if (count_down == 10'd1) break;
      step();
    end
    check_eq("cd_reach_1", count_down, 1);
    e = cyc;
    while (cyc < e + SEC_TICK - 1) step();
    score_inc = 1'b1;
    step();
    score_inc = 1'b0;
    check_eq("cd_tick_bonus", count_down, 1);
    check_eq("cd_tick_bonus_tu", time_up, 0);
    while (cyc < e + 2*SEC_TICK - 1) step();
    check_eq("cd_before_tick", count_down, 1);
    step();
    check_eq("cd_zero", count_down, 0);
    check_eq("cd_time_up", time_up, 1);
    repeat (SEC_TICK + 5) step();
    check_eq("cd_hold_zero", count_down, 0);
    game_run = 1'b0;
    step();
    check_eq("cd_reload", count_down, COUNT_INIT);
    check_eq("cd_tu_off", time_up, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
